phase_sequencer: RTL and testbench

// Frame scheduler between receiver and the per-channel phase_parser array. Buffers up to NUM_FRAMES full

---
 rtl/phase_seq_pkg.sv | 15 +
 rtl/phase_sequencer_frame_ram.sv | 33 +++
 rtl/phase_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_seq_pkg.sv
// Shared types and default sizing for the phase frame sequencer.
package phase_seq_pkg;

    localparam int WORD_W          = 32;
    localparam int FRAME_WORDS     = 128;
    localparam int DEF_NUM_FRAMES  = 4;
    localparam int FRAME_IDX_W     = $clog2(DEF_NUM_FRAMES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/phase_sequencer_frame_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module frame_ram
    import phase_seq_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Array is deliberately left without reset so it maps onto block RAM.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Buffers host-loaded phase frames and replays them to the phase parsers at a
// programmed frame period; passes host phase strobes straight through when idle.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_CHANNELS = FRAME_WORDS,
    parameter int NUM_FRAMES   = 2 ** FRAME_IDX_W,
    parameter int TICK_W       = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_parse_en,
    input  logic [WORD_W-1:0]             host_data,
    input  logic                          seq_wr_en,
    input  logic                          seq_commit,
    input  logic                          seq_clear,
    input  logic                          seq_start,
    input  logic                          seq_stop,
    input  logic                          seq_loop,
    input  logic [TICK_W-1:0]             seq_period,
    output logic                          phase_parse_en,
    output logic [WORD_W-1:0]             phase_data,
    output logic                          seq_busy,
    output logic [$clog2(NUM_FRAMES):0]   seq_frames,
    output logic [$clog2(NUM_FRAMES)-1:0] seq_frame_idx,
    output logic                          seq_overrun,
    output logic                          seq_error
);

    localparam int FW     = NUM_CHANNELS;
    localparam int WIDX_W = $clog2(FW);
    localparam int WPTR_W = $clog2(FW + 1);
    localparam int FI_W   = $clog2(NUM_FRAMES);
    localparam int FRM_W  = FI_W + 1;
    localparam int ADDR_W = FI_W + WIDX_W;

    seq_state_t        state_reg, state_next;

    logic [WPTR_W-1:0] wptr_reg, wptr_next;
    logic [FRM_W-1:0]  frames_reg, frames_next;
    logic [WIDX_W-1:0] rptr_reg, rptr_next;
    logic [FI_W-1:0]   frame_reg, frame_next;
    logic [TICK_W-1:0] elapsed_reg, elapsed_next;
    logic [TICK_W-1:0] period_reg, period_next;
    logic              loop_reg, loop_next;
    logic              stop_reg, stop_next;
    logic              done_reg, done_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              out_en_reg, out_en_next;
    logic [WORD_W-1:0] out_data_reg, out_data_next;
    logic              overrun_reg, overrun_next;
    logic              error_reg, error_next;

    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [WORD_W-1:0] rd_data;

    logic              last_word, last_frame, back_to_back, ending, finishing;
    logic              full, start_ok, frame_start, busy;
    logic [FI_W-1:0]   next_frame;

    assign busy         = (state_reg != IDLE);
    assign last_word    = (rptr_reg == WIDX_W'(FW - 1));
    assign last_frame   = ({1'b0, frame_reg} == (frames_reg - FRM_W'(1)));
    assign next_frame   = last_frame ? '0 : frame_reg + FI_W'(1);
    assign back_to_back = (period_reg <= TICK_W'(FW));
    assign full         = (frames_reg == FRM_W'(NUM_FRAMES));
    assign start_ok     = (state_reg == IDLE) && seq_start && (frames_reg != '0);
    // Ending: the frame now reading is the last one this run will play.
    assign ending       = stop_reg | seq_stop | (last_frame & ~loop_reg);
    assign finishing    = done_reg | stop_reg | seq_stop;
    assign frame_start  = (state_next == PLAY) && ((state_reg != PLAY) || last_word);

    frame_ram #(
        .DEPTH  (NUM_FRAMES * FW),
        .ADDR_W (ADDR_W),
        .DATA_W (WORD_W)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (host_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next = PLAY;
                end
            end
            PLAY: begin
                if (last_word && (ending || !back_to_back)) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Hold in WAIT until the last read word has left the RAM pipeline.
                if (finishing) begin
                    if (!rd_valid_reg) begin
                        state_next = IDLE;
                    end
                end else if ((elapsed_reg + TICK_W'(1)) == period_reg) begin
                    state_next = PLAY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_en         = (state_reg == PLAY);
        rd_addr       = {frame_reg, rptr_reg};
        wr_en         = 1'b0;
        wr_addr       = {frames_reg[FI_W-1:0], wptr_reg[WIDX_W-1:0]};
        wptr_next     = wptr_reg;
        frames_next   = frames_reg;
        rptr_next     = rd_en ? rptr_reg + WIDX_W'(1) : rptr_reg;
        elapsed_next  = elapsed_reg + TICK_W'(1);
        frame_next    = frame_reg;
        period_next   = period_reg;
        loop_next     = loop_reg;
        stop_next     = stop_reg;
        done_next     = done_reg;
        overrun_next  = overrun_reg;
        error_next    = error_reg;
        rd_valid_next = rd_en;

        out_en_next   = rd_valid_reg | (~busy & host_parse_en);
        out_data_next = rd_valid_reg ? rd_data : (busy ? out_data_reg : host_data);

        if (start_ok) begin
            period_next  = seq_period;
            loop_next    = seq_loop;
            overrun_next = 1'b0;
            error_next   = 1'b0;
        end else if (!busy && seq_start) begin
            error_next = 1'b1;
        end

        if (frame_start) begin
            rptr_next    = '0;
            elapsed_next = '0;
            frame_next   = busy ? next_frame : '0;
        end

        if (state_reg == PLAY && last_word) begin
            if (ending) begin
                done_next = 1'b1;
            end else if (period_reg < TICK_W'(FW)) begin
                overrun_next = 1'b1;
            end
        end

        if (busy && seq_stop) begin
            stop_next = 1'b1;
        end
        if (state_next == IDLE) begin
            stop_next = 1'b0;
            done_next = 1'b0;
        end

        if (!busy) begin
            if (seq_clear) begin
                frames_next = '0;
                wptr_next   = '0;
            end else if (seq_commit) begin
                if (wptr_reg == WPTR_W'(FW) && !full) begin
                    frames_next = frames_reg + FRM_W'(1);
                end else begin
                    error_next = 1'b1;
                end
                wptr_next = '0;
            end else if (seq_wr_en) begin
                if (wptr_reg == WPTR_W'(FW) || full) begin
                    error_next = 1'b1;
                    wptr_next  = '0;
                end else begin
                    wr_en     = 1'b1;
                    wptr_next = wptr_reg + WPTR_W'(1);
                end
            end
        end else if (seq_clear || seq_commit || seq_wr_en || host_parse_en) begin
            error_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg     <= '0;
            frames_reg   <= '0;
            rptr_reg     <= '0;
            frame_reg    <= '0;
            elapsed_reg  <= '0;
            period_reg   <= '0;
            loop_reg     <= 1'b0;
            stop_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rd_valid_reg <= 1'b0;
            out_en_reg   <= 1'b0;
            out_data_reg <= '0;
            overrun_reg  <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            frames_reg   <= frames_next;
            rptr_reg     <= rptr_next;
            frame_reg    <= frame_next;
            elapsed_reg  <= elapsed_next;
            period_reg   <= period_next;
            loop_reg     <= loop_next;
            stop_reg     <= stop_next;
            done_reg     <= done_next;
            rd_valid_reg <= rd_valid_next;
            out_en_reg   <= out_en_next;
            out_data_reg <= out_data_next;
            overrun_reg  <= overrun_next;
            error_reg    <= error_next;
        end
    end

    assign phase_parse_en = out_en_reg;
    assign phase_data     = out_data_reg;
    assign seq_busy       = busy;
    assign seq_frames     = frames_reg;
    assign seq_frame_idx  = frame_reg;
    assign seq_overrun    = overrun_reg;
    assign seq_error      = error_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer: observed strobe stream is compared
// against a cycle/data schedule computed from the frame-period rules.
module tb_phase_sequencer;

    localparam int FW = 128;
    localparam int NF = 4;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_parse_en = 1'b0;
    logic [31:0]   host_data = '0;
    logic          seq_wr_en = 1'b0;
    logic          seq_commit = 1'b0;
    logic          seq_clear = 1'b0;
    logic          seq_start = 1'b0;
    logic          seq_stop = 1'b0;
    logic          seq_loop = 1'b0;
    logic [TW-1:0] seq_period = '0;
    logic          phase_parse_en;
    logic [31:0]   phase_data;
    logic          seq_busy;
    logic [2:0]    seq_frames;
    logic [1:0]    seq_frame_idx;
    logic          seq_overrun;
    logic          seq_error;

    phase_sequencer #(
        .NUM_CHANNELS (FW),
        .NUM_FRAMES   (NF),
        .TICK_W       (TW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .host_parse_en  (host_parse_en),
        .host_data      (host_data),
        .seq_wr_en      (seq_wr_en),
        .seq_commit     (seq_commit),
        .seq_clear      (seq_clear),
        .seq_start      (seq_start),
        .seq_stop       (seq_stop),
        .seq_loop       (seq_loop),
        .seq_period     (seq_period),
        .phase_parse_en (phase_parse_en),
        .phase_data     (phase_data),
        .seq_busy       (seq_busy),
        .seq_frames     (seq_frames),
        .seq_frame_idx  (seq_frame_idx),
        .seq_overrun    (seq_overrun),
        .seq_error      (seq_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [NF][FW];
    int          obs_cyc[$];
    logic [31:0] obs_dat[$];
    int          want_cyc[$];
    logic [31:0] want_dat[$];
    int          vectors = 0;
    int          miscompares = 0;

    always @(negedge clk) begin
        if (phase_parse_en) begin
            obs_cyc.push_back(cyc);
            obs_dat.push_back(phase_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        obs_cyc.delete();
        obs_dat.delete();
    endtask

    task automatic fill_mem();
        for (int f = 0; f < NF; f++)
            for (int w = 0; w < FW; w++)
                mem[f][w] = $urandom;
    endtask

    task automatic load_frame(input int f);
        for (int w = 0; w < FW; w++) begin
            seq_wr_en = 1'b1;
            host_data = mem[f][w];
            tick(1);
        end
        seq_wr_en  = 1'b0;
        seq_commit = 1'b1;
        tick(1);
        seq_commit = 1'b0;
    endtask

    task automatic start_play(input int period, input logic loop, output int s);
        seq_period = TW'(period);
        seq_loop   = loop;
        seq_start  = 1'b1;
        s = cyc;
        tick(1);
        seq_start = 1'b0;
    endtask

    // Frame k starts max(period, FW) cycles after frame k-1; first strobe lands 3 cycles after start.
    task automatic model_play(input int s, input int played, input int stored, input int period);
        int step;
        step = (period > FW) ? period : FW;
        for (int k = 0; k < played; k++)
            for (int w = 0; w < FW; w++) begin
                want_cyc.push_back(s + 3 + k * step + w);
                want_dat.push_back(mem[k % stored][w]);
            end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (seq_busy && n < budget) begin
            tick(1);
            n++;
        end
        check({tag, "_idle"}, 64'(seq_busy), 64'(0));
        tick(4);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, 64'(obs_cyc.size()), 64'(want_cyc.size()));
        n = (obs_cyc.size() < want_cyc.size()) ? obs_cyc.size() : want_cyc.size();
        for (int i = 0; i < n; i++)
            check(tag, {32'(obs_cyc[i]), obs_dat[i]}, {32'(want_cyc[i]), want_dat[i]});
        $display("%s: %0d strobes observed, %0d expected", tag, obs_cyc.size(), want_cyc.size());
        obs_cyc.delete();
        obs_dat.delete();
        want_cyc.delete();
        want_dat.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_en"},      64'(phase_parse_en), 64'(0));
        check({tag, "_data"},    64'(phase_data),     64'(0));
        check({tag, "_busy"},    64'(seq_busy),       64'(0));
        check({tag, "_frames"},  64'(seq_frames),     64'(0));
        check({tag, "_idx"},     64'(seq_frame_idx),  64'(0));
        check({tag, "_overrun"}, 64'(seq_overrun),    64'(0));
        check({tag, "_error"},   64'(seq_error),      64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int played;
        int nf;
        int p;
        int ptab[5];
        logic [31:0] d;
        ptab = '{0, 60, 128, 129, 170};

        fill_mem();
        do_reset();
        check_zero("reset");

        // Idle passthrough, first pulse uses the documented word.
        for (int i = 0; i < 6; i++) begin
            tick($urandom_range(0, 3));
            d = (i == 0) ? 32'h0105_00AA : 32'($urandom);
            host_data     = d;
            host_parse_en = 1'b1;
            want_cyc.push_back(cyc + 1);
            want_dat.push_back(d);
            tick(1);
            host_parse_en = 1'b0;
        end
        tick(3);
        compare_stream("passthru");

        // Two frames, long period, single shot.
        do_reset();
        load_frame(0);
        load_frame(1);
        check("two_frames", 64'(seq_frames), 64'(2));
        start_play(200, 1'b0, s);
        model_play(s, 2, 2, 200);
        wait_idle("two_frame", 2 * 200 + 100);
        compare_stream("two_frame");
        check("two_frame_overrun", 64'(seq_overrun), 64'(0));
        check("two_frame_idx", 64'(seq_frame_idx), 64'(1));
        check("two_frame_frames", 64'(seq_frames), 64'(2));

        // One frame looping with short period, stopped mid-way through frame 2.
        do_reset();
        load_frame(0);
        start_play(50, 1'b1, s);
        c = s + 1 + 2 * FW + 40;
        while (cyc < c) tick(1);
        seq_stop = 1'b1;
        tick(1);
        seq_stop = 1'b0;
        played = (c - s - 1) / FW + 1;
        model_play(s, played, 1, 50);
        wait_idle("loop_stop", 6 * FW);
        compare_stream("loop_stop");
        check("loop_stop_overrun", 64'(seq_overrun), 64'(1));
        check("loop_stop_idx", 64'(seq_frame_idx), 64'(0));

        // Error cases.
        do_reset();
        seq_start = 1'b1;
        tick(1);
        seq_start = 1'b0;
        tick(1);
        check("start_empty_err", 64'(seq_error), 64'(1));
        check("start_empty_busy", 64'(seq_busy), 64'(0));
        compare_stream("start_empty");

        do_reset();
        for (int w = 0; w < 100; w++) begin
            seq_wr_en = 1'b1;
            host_data = $urandom;
            tick(1);
        end
        seq_wr_en  = 1'b0;
        seq_commit = 1'b1;
        tick(1);
        seq_commit = 1'b0;
        check("short_commit_err", 64'(seq_error), 64'(1));
        check("short_commit_frames", 64'(seq_frames), 64'(0));
        load_frame(0);
        check("reload_frames", 64'(seq_frames), 64'(1));
        start_play(0, 1'b0, s);
        check("start_clears_err", 64'(seq_error), 64'(0));
        while (cyc < s + 10) tick(1);
        host_data     = 32'hDEAD_BEEF;
        host_parse_en = 1'b1;
        tick(1);
        host_parse_en = 1'b0;
        check("host_busy_err", 64'(seq_error), 64'(1));
        model_play(s, 1, 1, 0);
        wait_idle("host_busy", 2 * FW);
        compare_stream("host_busy");
        check("host_busy_frames", 64'(seq_frames), 64'(1));
        check("single_overrun", 64'(seq_overrun), 64'(0));

        // Buffer full, then clear.
        do_reset();
        for (int f = 0; f < NF; f++) load_frame(f);
        check("full_frames", 64'(seq_frames), 64'(NF));
        seq_commit = 1'b1;
        tick(1);
        seq_commit = 1'b0;
        check("full_commit_err", 64'(seq_error), 64'(1));
        check("full_commit_frames", 64'(seq_frames), 64'(NF));
        seq_clear = 1'b1;
        tick(1);
        seq_clear = 1'b0;
        check("clear_frames", 64'(seq_frames), 64'(0));
        seq_start = 1'b1;
        tick(1);
        seq_start = 1'b0;
        tick(1);
        check("clear_start_busy", 64'(seq_busy), 64'(0));

        // Reset during playback at word 60.
        do_reset();
        host_data = '0;
        load_frame(2);
        host_data = '0;
        start_play(0, 1'b1, s);
        while (cyc < s + 3 + 60) tick(1);
        rst = 1'b1;
        tick(1);
        check_zero("mid_rst");
        rst = 1'b0;
        tick(300);
        for (int w = 0; w <= 60; w++) begin
            want_cyc.push_back(s + 3 + w);
            want_dat.push_back(mem[2][w]);
        end
        compare_stream("mid_rst");
        seq_start = 1'b1;
        tick(1);
        seq_start = 1'b0;
        tick(1);
        check("mid_rst_frames_lost", 64'(seq_error), 64'(1));

        // Randomized frame counts and periods.
        for (int it = 0; it < 5; it++) begin
            do_reset();
            fill_mem();
            nf = $urandom_range(1, NF);
            p  = ptab[$urandom_range(0, 4)];
            for (int f = 0; f < nf; f++) load_frame(f);
            start_play(p, 1'b0, s);
            model_play(s, nf, nf, p);
            wait_idle("rand", nf * (p + FW) + 64);
            $display("rand run %0d: frames=%0d period=%0d", it, nf, p);
            compare_stream("rand");
            check("rand_overrun", 64'(seq_overrun), 64'((p < FW) && (nf > 1)));
            check("rand_idx", 64'(seq_frame_idx), 64'(nf - 1));
            check("rand_frames", 64'(seq_frames), 64'(nf));
            check("rand_error", 64'(seq_error), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
